mc_controller: RTL and testbench
================================

// Module: mc_controller
// PURPOSE
//  Multi-cycle main controller for the 8-bit ARM-style datapath. Decodes Op/Funct/Cond from the
//  instruction register and sequences FETCH..WB states. Holds the NZCV flag register and gates
//  writes by the condition check. Adds a mem_ready wait handshake on memory states.
// PARAMETERS
//  FLAG_W    4   width of ALUFlags / internal NZCV register (fixed order N,Z,C,V = [3:0])
//  STATE_W   4   state register width (11 states used)
// PORTS
//  clk          in   1  rising-edge clock
//  reset        in   1  asynchronous, active-low reset (0 = reset)
//  Op           in   2  instr class: 00 data-proc, 01 LDR/STR, 10 branch, 11 enhanced data transfer
//  Funct        in   6  [5]=I, [4:1]=cmd, [0]=S (data-proc) / L (memory)
//  Cond         in   3  condition field
//  ALUFlags     in   4  live NZCV from datapath ALU
//  mem_ready    in   1  memory access complete this cycle
//  PCWrite      out  1  PC load enable
//  AdrSrc       out  1  0 = PC addresses memory, 1 = ALUOut
//  MemWrite     out  1  memory write strobe
//  IRWrite      out  1  instruction register load
//  RegWrite     out  1  register file write
//  RegSrc       out  3  [0]=Op==10, [1]=Op==01, [2]=Op==11
//  ImmSrc       out  2  = Op
//  AluSrcA      out  1  1 = PC, 0 = register
//  ALUSrcB      out  2  00 reg, 01 ext imm, 10 constant 1
//  ALUControl   out  3  000 ADD,001 SUB,010 AND,011 ORR,100 EOR,101 MOV
//  ResultSrc    out  2  00 ALUOut, 01 read data, 10 ALU result
//  enhanced_op  out  2  Funct[2:1] in MEMDT, else 00
//  state_out    out  4  current state (debug)
// BEHAVIOUR
//  - States: FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 EXECUTER=6 EXECUTEI=7 ALUWB=8
//    BRANCH=9 MEMDT=10; undefined codes -> FETCH next edge, all strobes 0.
//  - Reset (reset=0, async): state=FETCH, NZCV=0000. All outputs are combinational from state,
//    so in reset: IRWrite=1, PCWrite=0 (gated by mem_ready=0 is not required; PCWrite forced 0
//    while reset low), all other strobes 0.
//  - Transitions: FETCH->DECODE iff mem_ready, else hold. DECODE->EXECUTER (Op00,I=0),
//    EXECUTEI (Op00,I=1), MEMADR (Op01), BRANCH (Op10), MEMDT (Op11). MEMADR->MEMRD (L=1) /
//    MEMWR (L=0). MEMRD->MEMWB iff mem_ready. MEMWR->FETCH iff mem_ready. EXECUTER/I->ALUWB.
//    ALUWB, MEMWB, BRANCH->FETCH. MEMDT->MEMWB.
//  - Per state: FETCH IRWrite=mem_ready, NextPC=mem_ready, AluSrcA=1, ALUSrcB=10, ResultSrc=10.
//    DECODE AluSrcA=1, ALUSrcB=10, ResultSrc=10. EXECUTER ALUSrcB=00 ALUOp=1. EXECUTEI ALUSrcB=01
//    ALUOp=1. MEMADR/MEMDT ALUSrcB=01 ADD. MEMRD/MEMWR AdrSrc=1. MEMWR MemW=1. ALUWB RegW=1
//    ResultSrc=00. MEMWB RegW=1 ResultSrc=01. BRANCH Branch=1 ALUSrcB=01 ResultSrc=10.
//  - ALUOp=0 -> ADD. ALUOp=1 decode cmd: 0100 ADD,0010 SUB,0000 AND,1100 ORR,0001 EOR,1101 MOV,
//    1010 CMP (SUB, NoWrite=1); other cmd -> ADD with RegW suppressed.
//  - CondEx from stored NZCV: 000 EQ Z,001 NE !Z,010 CS C,011 CC !C,100 MI N,101 PL !N,
//    110 GE N==V,111 AL 1.
//  - Gating: PCWrite=NextPC | (Branch & CondEx); RegWrite=RegW & CondEx & !NoWrite;
//    MemWrite=MemW & CondEx & mem_ready-independent (held until mem_ready).
//  - NZCV <= ALUFlags on clk edge in EXECUTER/EXECUTEI when S=1 and CondEx; CMP always sets S
//    behaviour. Flags never change in other states.
//  - Failed condition still walks the full state path (fixed latency): DP 4, LDR 5, STR 4,
//    branch 3, MEMDT 4 cycles, plus one per extra mem_ready=0 cycle.
//  - Reset asserted mid-instruction aborts it: no pending write completes.
// CONFIGURATION
//  MC_PERF_EN defined: adds outputs cycle_cnt[15:0] (+1 each clk out of reset) and
//  retire_cnt[15:0] (+1 on every transition into FETCH from a non-FETCH state); both wrap
//  FFFF->0000, clear on reset. Undefined: ports and counters absent, no other change.
// TESTING
//  - Reset low with clk running -> state_out=0, NZCV=0, IRWrite=1, PCWrite=0, MemWrite=0.
//  - LDR (Op=01,Funct=000001,Cond=111), mem_ready=1 -> states 0,1,2,3,4; RegWrite=1 only in 4,
//    ResultSrc=01.
//  - SUB S (Op=00,Funct=100101), ALUFlags=0100 -> ALUControl=001 in 7, NZCV=0100, then BNE
//    (Op=10,Cond=001) -> BRANCH with PCWrite=0.
//  - CMP (cmd 1010,I=0) -> RegWrite=0 in ALUWB, NZCV updated.
//  - STR with mem_ready low 3 cycles in MEMWR -> MemWrite=1 held 4 cycles, then FETCH.
//  - Reset pulsed low during MEMWB -> immediate FETCH, RegWrite=0; MC_PERF_EN counters=0.

Source files
------------

// File: rtl/mc_controller.sv
// mc_controller -- multi-cycle main controller for the 8-bit ARM-style datapath.
//
// Decodes Op/Funct/Cond of the held instruction and walks FETCH..WB states.
// Keeps the NZCV flag register and gates PC/register/memory writes with the
// condition check. Memory states wait on mem_ready.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset (0 = reset)
//   Op/Funct/Cond instruction fields (Funct[5]=I, [4:1]=cmd, [0]=S or L)
//   ALUFlags     live NZCV from the ALU ([3]=N [2]=Z [1]=C [0]=V)
//   mem_ready    memory access completes this cycle
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite   datapath strobes/selects
//   RegSrc, ImmSrc, AluSrcA, ALUSrcB, ALUControl, ResultSrc  datapath selects
//   enhanced_op  Funct[2:1] while in MEMDT, else 00
//   state_out    current state (debug)
//
// Optional feature: define MC_PERF_EN to add cycle_cnt[15:0] and
// retire_cnt[15:0] performance counters.

module mc_controller #(
    parameter int FLAG_W  = 4,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         Op,
    input  logic [5:0]         Funct,
    input  logic [2:0]         Cond,
    input  logic [FLAG_W-1:0]  ALUFlags,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic [2:0]         RegSrc,
    output logic [1:0]         ImmSrc,
    output logic               AluSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [2:0]         ALUControl,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         enhanced_op,
    output logic [STATE_W-1:0] state_out
`ifdef MC_PERF_EN
    ,
    output logic [15:0]        cycle_cnt,
    output logic [15:0]        retire_cnt
`endif
);

    typedef enum logic [STATE_W-1:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        MEMDT    = 4'd10
    } state_t;

    state_t            state, next_state;
    logic [FLAG_W-1:0] nzcv;

    logic       next_pc, branch, reg_w, mem_w, alu_op;
    logic       cond_ex, no_write, is_cmp, cmd_illegal;
    logic [2:0] dp_ctrl;

    // Data-processing command decode
    always_comb begin
        dp_ctrl     = 3'b000;
        is_cmp      = 1'b0;
        cmd_illegal = 1'b0;
        case (Funct[4:1])
            4'b0100: dp_ctrl = 3'b000;
            4'b0010: dp_ctrl = 3'b001;
            4'b0000: dp_ctrl = 3'b010;
            4'b1100: dp_ctrl = 3'b011;
            4'b0001: dp_ctrl = 3'b100;
            4'b1101: dp_ctrl = 3'b101;
            4'b1010: begin dp_ctrl = 3'b001; is_cmp = 1'b1; end
            default: cmd_illegal = 1'b1;
        endcase
    end

    // cmd bits of memory instructions are addressing-mode bits, so the
    // write suppression only applies to data-processing instructions
    assign no_write = (Op == 2'b00) && (is_cmp || cmd_illegal);

    // Condition check against the stored flags
    always_comb begin
        case (Cond)
            3'b000:  cond_ex = nzcv[2];
            3'b001:  cond_ex = ~nzcv[2];
            3'b010:  cond_ex = nzcv[1];
            3'b011:  cond_ex = ~nzcv[1];
            3'b100:  cond_ex = nzcv[3];
            3'b101:  cond_ex = ~nzcv[3];
            3'b110:  cond_ex = (nzcv[3] == nzcv[0]);
            default: cond_ex = 1'b1;
        endcase
    end

    // Next state and per-state control
    always_comb begin
        next_state  = FETCH;
        IRWrite     = 1'b0;
        next_pc     = 1'b0;
        branch      = 1'b0;
        reg_w       = 1'b0;
        mem_w       = 1'b0;
        alu_op      = 1'b0;
        AdrSrc      = 1'b0;
        AluSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ResultSrc   = 2'b00;
        enhanced_op = 2'b00;
        case (state)
            FETCH: begin
                // IR load is held high while in reset so the fetch path is primed
                IRWrite    = mem_ready | ~reset;
                next_pc    = mem_ready;
                AluSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                next_state = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                AluSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (Op)
                    2'b00:   next_state = Funct[5] ? EXECUTEI : EXECUTER;
                    2'b01:   next_state = MEMADR;
                    2'b10:   next_state = BRANCH;
                    default: next_state = MEMDT;
                endcase
            end
            MEMADR: begin
                ALUSrcB    = 2'b01;
                next_state = Funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                AdrSrc     = 1'b1;
                next_state = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                reg_w     = 1'b1;
                ResultSrc = 2'b01;
            end
            MEMWR: begin
                AdrSrc     = 1'b1;
                mem_w      = 1'b1;
                next_state = mem_ready ? FETCH : MEMWR;
            end
            EXECUTER: begin
                alu_op     = 1'b1;
                next_state = ALUWB;
            end
            EXECUTEI: begin
                ALUSrcB    = 2'b01;
                alu_op     = 1'b1;
                next_state = ALUWB;
            end
            ALUWB: reg_w = 1'b1;
            BRANCH: begin
                branch    = 1'b1;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
            end
            MEMDT: begin
                ALUSrcB     = 2'b01;
                enhanced_op = Funct[2:1];
                next_state  = MEMWB;
            end
            default: next_state = FETCH;
        endcase
    end

    assign ALUControl = alu_op ? dp_ctrl : 3'b000;
    assign PCWrite    = reset & (next_pc | (branch & cond_ex));
    assign RegWrite   = reg_w & cond_ex & ~no_write;
    assign MemWrite   = mem_w & cond_ex;
    assign RegSrc     = {Op == 2'b11, Op == 2'b01, Op == 2'b10};
    assign ImmSrc     = Op;
    assign state_out  = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
            nzcv  <= '0;
        end else begin
            state <= next_state;
            // CMP updates flags regardless of its S bit
            if ((state == EXECUTER || state == EXECUTEI) && (Funct[0] || is_cmp) && cond_ex)
                nzcv <= ALUFlags;
        end
    end

`ifdef MC_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 16'd1;
            if (state != FETCH && next_state == FETCH)
                retire_cnt <= retire_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller -- scenario-driven bench for mc_controller.
// Each scenario queues (mem_ready, expected output vector) steps; every step is
// popped on a falling edge, driven, and compared with the packed outputs.
// Packed vector: {state, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc,
//                 ResultSrc, ALUSrcB, ALUControl, AluSrcA, enhanced_op}

module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [2:0] Cond;
    logic [3:0] ALUFlags;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, AluSrcA;
    logic [2:0] RegSrc, ALUControl;
    logic [1:0] ImmSrc, ALUSrcB, ResultSrc, enhanced_op;
    logic [3:0] state_out;
`ifdef MC_PERF_EN
    logic [15:0] cycle_cnt, retire_cnt;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        mr;
        logic [18:0] exp;
    } step_t;

    step_t sbq[$];

    logic [18:0] obs;
    assign obs = {state_out, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc,
                  ResultSrc, ALUSrcB, ALUControl, AluSrcA, enhanced_op};

    mc_controller #(.FLAG_W(4), .STATE_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .Op         (Op),
        .Funct      (Funct),
        .Cond       (Cond),
        .ALUFlags   (ALUFlags),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .RegSrc     (RegSrc),
        .ImmSrc     (ImmSrc),
        .AluSrcA    (AluSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ResultSrc  (ResultSrc),
        .enhanced_op(enhanced_op),
        .state_out  (state_out)
`ifdef MC_PERF_EN
        ,
        .cycle_cnt  (cycle_cnt),
        .retire_cnt (retire_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [18:0] ex(input logic [3:0] st, input logic pcw, input logic irw,
                                       input logic rw, input logic mw, input logic adr,
                                       input logic [1:0] rs, input logic [1:0] sb,
                                       input logic [2:0] ac, input logic sa, input logic [1:0] eo);
        return {st, pcw, irw, rw, mw, adr, rs, sb, ac, sa, eo};
    endfunction

    // Common expected vectors
    function automatic logic [18:0] v_fetch_go();
        return ex(4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 3'b000, 1'b1, 2'b00);
    endfunction
    function automatic logic [18:0] v_decode();
        return ex(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 3'b000, 1'b1, 2'b00);
    endfunction

    task automatic test_reset();
        logic [18:0] e;
        e = ex(4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 3'b000, 1'b1, 2'b00);
        reset = 1'b0; mem_ready = 1'b0; Op = 2'b00; Funct = '0; Cond = 3'b111; ALUFlags = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL reset_idle: got %h expected %h", obs, e);
        end
        mem_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL reset_memready: got %h expected %h", obs, e);
        end
`ifdef MC_PERF_EN
        checks++;
        if (cycle_cnt !== 16'd0 || retire_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_perf: got %h/%h expected 0000/0000", cycle_cnt, retire_cnt);
        end
`endif
        @(negedge clk);
        mem_ready = 1'b0;
        reset = 1'b1;
    endtask

    task automatic test_ldr();
        int n = 0;
        Op = 2'b01; Funct = 6'b000001; Cond = 3'b111;
        sbq.push_back('{1'b1, v_fetch_go()});
        sbq.push_back('{1'b1, v_decode()});
        sbq.push_back('{1'b1, ex(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 3'b000, 1'b0, 2'b00)});
        sbq.push_back('{1'b1, ex(4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00)});
        sbq.push_back('{1'b1, ex(4'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 3'b000, 1'b0, 2'b00)});
        while (sbq.size() > 0) begin
            step_t s;
            s = sbq.pop_front();
            @(negedge clk);
            mem_ready = s.mr;
            #1;
            checks++;
            if (obs !== s.exp) begin
                errors++;
                $display("FAIL ldr step %0d: got %h expected %h", n, obs, s.exp);
            end
            n++;
        end
        checks++;
        if (RegSrc !== 3'b010 || ImmSrc !== 2'b01) begin
            errors++;
            $display("FAIL ldr_regsrc: got %b/%b expected 010/01", RegSrc, ImmSrc);
        end
    endtask

    task automatic test_branch(input logic [2:0] c, input logic taken, input string name);
        int n = 0;
        Op = 2'b10; Funct = 6'b000000; Cond = c;
        sbq.push_back('{1'b1, v_fetch_go()});
        sbq.push_back('{1'b1, v_decode()});
        sbq.push_back('{1'b1, ex(4'd9, taken, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 3'b000, 1'b0, 2'b00)});
        while (sbq.size() > 0) begin
            step_t s;
            s = sbq.pop_front();
            @(negedge clk);
            mem_ready = s.mr;
            #1;
            checks++;
            if (obs !== s.exp) begin
                errors++;
                $display("FAIL %s step %0d: got %h expected %h", name, n, obs, s.exp);
            end
            n++;
        end
    endtask

    // SUBS immediate with Z result; later branches observe the stored Z flag
    task automatic test_sub_flags();
        int n = 0;
        Op = 2'b00; Funct = 6'b100101; Cond = 3'b111; ALUFlags = 4'b0100;
        sbq.push_back('{1'b1, v_fetch_go()});
        sbq.push_back('{1'b1, v_decode()});
        sbq.push_back('{1'b1, ex(4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 3'b001, 1'b0, 2'b00)});
        sbq.push_back('{1'b1, ex(4'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00)});
        while (sbq.size() > 0) begin
            step_t s;
            s = sbq.pop_front();
            @(negedge clk);
            mem_ready = s.mr;
            #1;
            checks++;
            if (obs !== s.exp) begin
                errors++;
                $display("FAIL sub_s step %0d: got %h expected %h", n, obs, s.exp);
            end
            n++;
        end
    endtask

    // CMP register form, S=0: no register write but flags become C only
    task automatic test_cmp();
        int n = 0;
        Op = 2'b00; Funct = 6'b010100; Cond = 3'b111; ALUFlags = 4'b0010;
        sbq.push_back('{1'b1, v_fetch_go()});
        sbq.push_back('{1'b1, v_decode()});
        sbq.push_back('{1'b1, ex(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 3'b001, 1'b0, 2'b00)});
        sbq.push_back('{1'b1, ex(4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00)});
        while (sbq.size() > 0) begin
            step_t s;
            s = sbq.pop_front();
            @(negedge clk);
            mem_ready = s.mr;
            #1;
            checks++;
            if (obs !== s.exp) begin
                errors++;
                $display("FAIL cmp step %0d: got %h expected %h", n, obs, s.exp);
            end
            n++;
        end
    endtask

    // ADDEQS with Z clear: full path, no write, flags untouched; then an
    // illegal cmd that falls back to ADD with the write suppressed
    task automatic test_cond_fail();
        int n = 0;
        Op = 2'b00; Funct = 6'b101001; Cond = 3'b000; ALUFlags = 4'b1000;
        sbq.push_back('{1'b1, v_fetch_go()});
        sbq.push_back('{1'b1, v_decode()});
        sbq.push_back('{1'b1, ex(4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 3'b000, 1'b0, 2'b00)});
        sbq.push_back('{1'b1, ex(4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00)});
        while (sbq.size() > 0) begin
            step_t s;
            s = sbq.pop_front();
            @(negedge clk);
            mem_ready = s.mr;
            #1;
            checks++;
            if (obs !== s.exp) begin
                errors++;
                $display("FAIL cond_fail step %0d: got %h expected %h", n, obs, s.exp);
            end
            n++;
        end
        n = 0;
        Op = 2'b00; Funct = 6'b000110; Cond = 3'b111;
        sbq.push_back('{1'b1, v_fetch_go()});
        sbq.push_back('{1'b1, v_decode()});
        sbq.push_back('{1'b1, ex(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00)});
        sbq.push_back('{1'b1, ex(4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00)});
        while (sbq.size() > 0) begin
            step_t s;
            s = sbq.pop_front();
            @(negedge clk);
            mem_ready = s.mr;
            #1;
            checks++;
            if (obs !== s.exp) begin
                errors++;
                $display("FAIL illegal_cmd step %0d: got %h expected %h", n, obs, s.exp);
            end
            n++;
        end
    endtask

    // STR with a fetch stall and three wait cycles in MEMWR
    task automatic test_str_wait();
        int n = 0;
        logic [18:0] wr;
        wr = ex(4'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00);
        Op = 2'b01; Funct = 6'b000000; Cond = 3'b111;
        sbq.push_back('{1'b0, ex(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 3'b000, 1'b1, 2'b00)});
        sbq.push_back('{1'b1, v_fetch_go()});
        sbq.push_back('{1'b1, v_decode()});
        sbq.push_back('{1'b0, ex(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 3'b000, 1'b0, 2'b00)});
        sbq.push_back('{1'b0, wr});
        sbq.push_back('{1'b0, wr});
        sbq.push_back('{1'b0, wr});
        sbq.push_back('{1'b1, wr});
        sbq.push_back('{1'b0, ex(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 3'b000, 1'b1, 2'b00)});
        while (sbq.size() > 0) begin
            step_t s;
            s = sbq.pop_front();
            @(negedge clk);
            mem_ready = s.mr;
            #1;
            checks++;
            if (obs !== s.exp) begin
                errors++;
                $display("FAIL str_wait step %0d: got %h expected %h", n, obs, s.exp);
            end
            n++;
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        Op = 2'b11; Funct = 6'b000100; Cond = 3'b111;
        sbq.push_back('{1'b1, v_fetch_go()});
        sbq.push_back('{1'b1, v_decode()});
        sbq.push_back('{1'b1, ex(4'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 3'b000, 1'b0, 2'b10)});
        sbq.push_back('{1'b1, ex(4'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 3'b000, 1'b0, 2'b00)});
        while (sbq.size() > 0) begin
            step_t s;
            s = sbq.pop_front();
            @(negedge clk);
            mem_ready = s.mr;
            #1;
            checks++;
            if (obs !== s.exp) begin
                errors++;
                $display("FAIL memdt step %0d: got %h expected %h", n, obs, s.exp);
            end
            n++;
        end
        checks++;
        if (RegSrc !== 3'b100 || ImmSrc !== 2'b11) begin
            errors++;
            $display("FAIL memdt_regsrc: got %b/%b expected 100/11", RegSrc, ImmSrc);
        end
    endtask

    // LDR interrupted by reset in MEMWB
    task automatic test_reset_mid();
        int n = 0;
        logic [18:0] e;
        e = ex(4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 3'b000, 1'b1, 2'b00);
        Op = 2'b01; Funct = 6'b000001; Cond = 3'b111;
        sbq.push_back('{1'b1, v_fetch_go()});
        sbq.push_back('{1'b1, v_decode()});
        sbq.push_back('{1'b1, ex(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 3'b000, 1'b0, 2'b00)});
        sbq.push_back('{1'b1, ex(4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00)});
        sbq.push_back('{1'b1, ex(4'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 3'b000, 1'b0, 2'b00)});
        while (sbq.size() > 0) begin
            step_t s;
            s = sbq.pop_front();
            @(negedge clk);
            mem_ready = s.mr;
            #1;
            checks++;
            if (obs !== s.exp) begin
                errors++;
                $display("FAIL reset_mid step %0d: got %h expected %h", n, obs, s.exp);
            end
            n++;
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL reset_mid_abort: got %h expected %h", obs, e);
        end
`ifdef MC_PERF_EN
        checks++;
        if (cycle_cnt !== 16'd0 || retire_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid_perf: got %h/%h expected 0000/0000", cycle_cnt, retire_cnt);
        end
`endif
        @(negedge clk);
        mem_ready = 1'b0;
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_branch(3'b000, 1'b0, "beq_after_reset");
        test_ldr();
        test_sub_flags();
        test_branch(3'b001, 1'b0, "bne_z_set");
        test_branch(3'b000, 1'b1, "beq_z_set");
        test_cmp();
        test_branch(3'b010, 1'b1, "bcs_c_set");
        test_branch(3'b000, 1'b0, "beq_z_clear");
        test_cond_fail();
        test_branch(3'b100, 1'b0, "bmi_unchanged");
        test_branch(3'b110, 1'b1, "bge");
        test_str_wait();
        test_back_to_back();
        test_reset_mid();
        test_branch(3'b010, 1'b0, "bcs_after_reset");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
